// File: rtl/reg_file.sv
// reg_file: 32 x 32-bit general-purpose register file for the OpenMIPS pipeline.
// One synchronous write port (write-back) and two independent combinational
// read ports (decode). Register 0 is hard-wired to zero.
// Optional build macro: REGFILE_BYPASS_EN enables same-cycle write-to-read
// forwarding on both read ports. Without it a read returns the stored value
// and a write becomes visible just after its clock edge.
module reg_file #(
  parameter int N_REG      = 32,
  parameter int N_REG_ADDR = 5
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [N_REG_ADDR-1:0] i_waddr,
  input  logic [N_REG-1:0]      i_wdata,
  input  logic                  i_wen,
  input  logic [N_REG_ADDR-1:0] i_raddr_0,
  input  logic                  i_ren_0,
  output logic [N_REG-1:0]      o_rdata_0,
  input  logic [N_REG_ADDR-1:0] i_raddr_1,
  input  logic                  i_ren_1,
  output logic [N_REG-1:0]      o_rdata_1
);

  localparam int NUM_REGS = 2 ** N_REG_ADDR;

  logic [N_REG-1:0] regs_q [NUM_REGS];
  logic [N_REG-1:0] regs_d [NUM_REGS];
  logic [N_REG-1:0] rdata_0_s;
  logic [N_REG-1:0] rdata_1_s;

  // Next-state of the array: only the addressed non-zero register takes new data.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      if (i == 0) begin
        regs_d[i] = {N_REG{1'b0}};
      end else if (i_wen && (i_waddr == N_REG_ADDR'(i))) begin
        regs_d[i] = i_wdata;
      end else begin
        regs_d[i] = regs_q[i];
      end
    end
  end

  // Register array state: cleared asynchronously, updated on every rising edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= {N_REG{1'b0}};
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Read port 0: reset, disable and register 0 all force zero ahead of any data.
  always_comb begin
    rdata_0_s = {N_REG{1'b0}};
    if (!i_rst_n) begin
      rdata_0_s = {N_REG{1'b0}};
    end else if (!i_ren_0) begin
      rdata_0_s = {N_REG{1'b0}};
    end else if (i_raddr_0 == {N_REG_ADDR{1'b0}}) begin
      rdata_0_s = {N_REG{1'b0}};
`ifdef REGFILE_BYPASS_EN
    end else if (i_wen && (i_waddr == i_raddr_0)) begin
      rdata_0_s = i_wdata;
`endif
    end else begin
      rdata_0_s = regs_q[i_raddr_0];
    end
  end

  // Read port 1: same priority as port 0, fully independent of it.
  always_comb begin
    rdata_1_s = {N_REG{1'b0}};
    if (!i_rst_n) begin
      rdata_1_s = {N_REG{1'b0}};
    end else if (!i_ren_1) begin
      rdata_1_s = {N_REG{1'b0}};
    end else if (i_raddr_1 == {N_REG_ADDR{1'b0}}) begin
      rdata_1_s = {N_REG{1'b0}};
`ifdef REGFILE_BYPASS_EN
    end else if (i_wen && (i_waddr == i_raddr_1)) begin
      rdata_1_s = i_wdata;
`endif
    end else begin
      rdata_1_s = regs_q[i_raddr_1];
    end
  end

  assign o_rdata_0 = rdata_0_s;
  assign o_rdata_1 = rdata_1_s;

endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed self-checking bench for reg_file.
module tb_reg_file;

  logic        i_clk;
  logic        i_rst_n;
  logic [4:0]  i_waddr;
  logic [31:0] i_wdata;
  logic        i_wen;
  logic [4:0]  i_raddr_0;
  logic        i_ren_0;
  logic [31:0] o_rdata_0;
  logic [4:0]  i_raddr_1;
  logic        i_ren_1;
  logic [31:0] o_rdata_1;

  int errors = 0;
  int checks = 0;

  reg_file #(.N_REG(32), .N_REG_ADDR(5)) dut (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_waddr   (i_waddr),
    .i_wdata   (i_wdata),
    .i_wen     (i_wen),
    .i_raddr_0 (i_raddr_0),
    .i_ren_0   (i_ren_0),
    .o_rdata_0 (o_rdata_0),
    .i_raddr_1 (i_raddr_1),
    .i_ren_1   (i_ren_1),
    .o_rdata_1 (o_rdata_1)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Move to just after the next rising edge.
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    i_rst_n   = 1'b0;
    i_waddr   = 5'd0;
    i_wdata   = 32'd0;
    i_wen     = 1'b0;
    i_raddr_0 = 5'd5;
    i_ren_0   = 1'b1;
    i_raddr_1 = 5'd9;
    i_ren_1   = 1'b1;

    // Reset held for one cycle
    step();
    check("rst_hold_p0", o_rdata_0, 32'd0);
    check("rst_hold_p1", o_rdata_1, 32'd0);
    i_rst_n = 1'b1;
    #1;

    // Reset then read every address on both ports
    for (int i = 0; i < 32; i++) begin
      i_raddr_0 = 5'(i);
      i_raddr_1 = 5'(31 - i);
      #1;
      check($sformatf("rst_read_p0[%0d]", i), o_rdata_0, 32'd0);
      check($sformatf("rst_read_p1[%0d]", 31 - i), o_rdata_1, 32'd0);
    end

    // Fill: reg i <= i+1 on consecutive cycles (write to reg 0 is discarded)
    for (int i = 0; i < 32; i++) begin
      i_wen   = 1'b1;
      i_waddr = 5'(i);
      i_wdata = 32'(i + 1);
      step();
    end
    i_wen = 1'b0;
    #1;

    // Read back
    for (int i = 0; i < 32; i++) begin
      i_raddr_0 = 5'(i);
      i_raddr_1 = 5'(i);
      #1;
      check($sformatf("fill_p0[%0d]", i), o_rdata_0, (i == 0) ? 32'd0 : 32'(i + 1));
      check($sformatf("fill_p1[%0d]", i), o_rdata_1, (i == 0) ? 32'd0 : 32'(i + 1));
    end

    // Read disable
    i_raddr_0 = 5'd7;
    i_raddr_1 = 5'd7;
    i_ren_0   = 1'b0;
    i_ren_1   = 1'b0;
    #1;
    check("ren_off_p0", o_rdata_0, 32'd0);
    check("ren_off_p1", o_rdata_1, 32'd0);
    i_ren_0 = 1'b1;
    i_ren_1 = 1'b1;
    #1;
    check("ren_on_p0", o_rdata_0, 32'd8);
    check("ren_on_p1", o_rdata_1, 32'd8);

    // Write enable low leaves the array unchanged
    i_wen   = 1'b0;
    i_waddr = 5'd7;
    i_wdata = 32'hDEAD_BEEF;
    step();
    check("wen_off_p0", o_rdata_0, 32'd8);

    // Same-cycle write/read of reg 5 on port 0
    i_raddr_0 = 5'd5;
    i_raddr_1 = 5'd6;
    i_wen     = 1'b1;
    i_waddr   = 5'd5;
    i_wdata   = 32'd666;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("same_cycle_p0", o_rdata_0, 32'd666);
`else
    check("same_cycle_p0", o_rdata_0, 32'd6);
`endif
    check("same_cycle_other_p1", o_rdata_1, 32'd7);
    step();
    i_wen = 1'b0;
    #1;
    check("after_write_p0", o_rdata_0, 32'd666);

    // Same-cycle write/read of reg 9 on port 1
    i_raddr_1 = 5'd9;
    i_wen     = 1'b1;
    i_waddr   = 5'd9;
    i_wdata   = 32'hA5A5_0909;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("same_cycle_p1", o_rdata_1, 32'hA5A5_0909);
`else
    check("same_cycle_p1", o_rdata_1, 32'd10);
`endif
    step();
    i_wen = 1'b0;
    #1;
    check("after_write_p1", o_rdata_1, 32'hA5A5_0909);

    // Write to reg 0 while reading it: never forwarded, never stored
    i_raddr_0 = 5'd0;
    i_wen     = 1'b1;
    i_waddr   = 5'd0;
    i_wdata   = 32'hFFFF_FFFF;
    #1;
    check("r0_during_write", o_rdata_0, 32'd0);
    step();
    i_wen = 1'b0;
    #1;
    check("r0_after_write", o_rdata_0, 32'd0);

    // Dual-port independence and swap
    i_raddr_0 = 5'd3;
    i_raddr_1 = 5'd30;
    #1;
    check("dual_p0", o_rdata_0, 32'd4);
    check("dual_p1", o_rdata_1, 32'd31);
    i_raddr_0 = 5'd30;
    i_raddr_1 = 5'd3;
    #1;
    check("swap_p0", o_rdata_0, 32'd31);
    check("swap_p1", o_rdata_1, 32'd4);

    // Async reset mid-operation: outputs drop between edges
    i_raddr_0 = 5'd5;
    i_raddr_1 = 5'd30;
    #1;
    check("pre_rst_p0", o_rdata_0, 32'd666);
    @(negedge i_clk);
    i_rst_n = 1'b0;
    #1;
    check("async_rst_p0", o_rdata_0, 32'd0);
    check("async_rst_p1", o_rdata_1, 32'd0);
    // A write attempted while reset is held must be ignored
    i_wen   = 1'b1;
    i_waddr = 5'd10;
    i_wdata = 32'h0BAD_0BAD;
    step();
    i_wen = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    i_raddr_1 = 5'd10;
    #1;
    check("post_rst_r5", o_rdata_0, 32'd0);
    check("rst_write_ignored", o_rdata_1, 32'd0);

    // Reset released between edges with a write pending: first edge writes
    @(negedge i_clk);
    i_rst_n = 1'b0;
    #1;
    i_wen   = 1'b1;
    i_waddr = 5'd5;
    i_wdata = 32'h0000_1234;
    i_rst_n = 1'b1;
    step();
    i_wen = 1'b0;
    #1;
    check("first_edge_write", o_rdata_0, 32'h0000_1234);
    i_raddr_1 = 5'd5;
    #1;
    check("first_edge_write_p1", o_rdata_1, 32'h0000_1234);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
